// File: rtl/arbiter_requester_pkg.sv
// Shared types for the round-robin arbiter client agent: buffered beat layout and FSM states.
// The module-level width parameters default to the widths below and must match them.
package arbiter_requester_pkg;

    localparam int unsigned PKG_ADDR_WIDTH = 32;
    localparam int unsigned PKG_DATA_WIDTH = 32;

    typedef struct packed {
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic                      wr;
        logic [PKG_DATA_WIDTH-1:0] wdata;
        logic                      last;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BURST
    } state_e;

endpackage

// File: rtl/requester_fifo.sv
// Synchronous beat FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module requester_fifo
    import arbiter_requester_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  beat_t                      din,
    input  logic                       pop,
    output beat_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    beat_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // so resetting the data would just add reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/arbiter_requester.sv
// Client agent for a round-robin arbiter: buffers locked beat sequences, requests once a whole
// sequence is queued, holds the grant across the sequence and returns read data to the master.
module arbiter_requester
    import arbiter_requester_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_last,
    output logic                  request,
    input  logic                  grant,
    output logic                  hold,
    output logic                  bus_valid,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  seq_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    beat_t            cmd_beat;
    beat_t            head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             issue;
    logic             seq_inc;
    logic             seq_dec;
    state_e           state_q, state_d;
    state_e           after_last;
    logic [CNT_W-1:0] seq_count_q, seq_count_d;
    logic             seq_err_q, seq_err_d;
    logic             rsp_valid_q;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign cmd_beat  = '{addr: cmd_addr, wr: cmd_wr, wdata: cmd_wdata, last: cmd_last};

    requester_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (cmd_beat),
        .pop   (issue),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // request depends on state only, so there is no combinational grant -> request path.
    assign request   = (state_q != IDLE);
    assign issue     = request && grant && !fifo_empty;
    assign hold      = issue && !head.last;
    assign bus_valid = issue;
    assign bus_addr  = issue ? head.addr  : '0;
    assign bus_wr    = issue && head.wr;
    assign bus_wdata = issue ? head.wdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_valid_q ? bus_rdata : '0;
    assign seq_err   = seq_err_q;

    assign seq_inc = push && cmd_last;
    assign seq_dec = issue && head.last;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        seq_count_d = seq_count_q;
        if (seq_inc && !seq_dec) begin
            seq_count_d = seq_count_q + CNT_W'(1);
        end else if (seq_dec && !seq_inc) begin
            seq_count_d = seq_count_q - CNT_W'(1);
        end
    end

    // Exits key off the post-update count so a sequence completing in this cycle is seen at once.
    always_comb begin
        state_d    = state_q;
        seq_err_d  = seq_err_q;
        after_last = (seq_count_d == '0) ? IDLE : ARB;
        case (state_q)
            IDLE: begin
                if (seq_count_d != '0) state_d = ARB;
            end
            ARB: begin
                if (grant) state_d = head.last ? after_last : BURST;
            end
            BURST: begin
                if (grant) begin
                    if (head.last) state_d = after_last;
                end else begin
                    seq_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A full buffer with no complete sequence can never drain: oversize sequence.
        if (fifo_count == CNT_W'(FIFO_DEPTH) && seq_count_q == '0) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seq_count_q <= '0;
            seq_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_count_q <= seq_count_d;
            seq_err_q   <= seq_err_d;
            rsp_valid_q <= issue && !head.wr;
        end
    end

endmodule

// File: tb/tb_arbiter_requester.sv
// Directed bench: one cycle-by-cycle vector table plus multi-cycle sequences, including two
// requesters sharing a small round-robin arbiter model with hold support.
module tb_arbiter_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_mode;
    logic        gnt_en_a;

    logic        cmd_valid_a, cmd_wr_a, cmd_last_a, cmd_ready_a;
    logic [31:0] cmd_addr_a, cmd_wdata_a;
    logic        request_a, grant_a, hold_a, bus_valid_a, bus_wr_a, rsp_valid_a, seq_err_a;
    logic [31:0] bus_addr_a, bus_wdata_a, bus_rdata_a, rsp_rdata_a;

    logic        cmd_valid_b, cmd_wr_b, cmd_last_b, cmd_ready_b;
    logic [31:0] cmd_addr_b, cmd_wdata_b;
    logic        request_b, grant_b, hold_b, bus_valid_b, bus_wr_b, rsp_valid_b, seq_err_b;
    logic [31:0] bus_addr_b, bus_wdata_b, bus_rdata_b, rsp_rdata_b;

    logic [1:0]  arb_req, arb_gnt;
    logic        arb_hold, lock_q, owner_q, ptr_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arbiter_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_addr(cmd_addr_a),
        .cmd_wr(cmd_wr_a), .cmd_wdata(cmd_wdata_a), .cmd_last(cmd_last_a),
        .request(request_a), .grant(grant_a), .hold(hold_a),
        .bus_valid(bus_valid_a), .bus_addr(bus_addr_a), .bus_wr(bus_wr_a),
        .bus_wdata(bus_wdata_a), .bus_rdata(bus_rdata_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .seq_err(seq_err_a)
    );

    arbiter_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr_b),
        .cmd_wr(cmd_wr_b), .cmd_wdata(cmd_wdata_b), .cmd_last(cmd_last_b),
        .request(request_b), .grant(grant_b), .hold(hold_b),
        .bus_valid(bus_valid_b), .bus_addr(bus_addr_b), .bus_wr(bus_wr_b),
        .bus_wdata(bus_wdata_b), .bus_rdata(bus_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .seq_err(seq_err_b)
    );

    // Round-robin arbiter model for two clients; a held grant stays with its owner.
    assign arb_req  = arb_mode ? {request_b, request_a} : 2'b00;
    assign arb_hold = arb_mode & (hold_a | hold_b);
    assign grant_a  = arb_mode ? arb_gnt[0] : (request_a & gnt_en_a);
    assign grant_b  = arb_mode ? arb_gnt[1] : 1'b0;

    always_comb begin
        arb_gnt = 2'b00;
        if (lock_q) arb_gnt[owner_q] = arb_req[owner_q];
        else if (arb_req[ptr_q]) arb_gnt[ptr_q] = 1'b1;
        else if (arb_req[~ptr_q]) arb_gnt[~ptr_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else if (arb_gnt != 2'b00) begin
            owner_q <= arb_gnt[1];
            lock_q  <= arb_hold;
            if (!arb_hold) ptr_q <= ~arb_gnt[1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        last;
        logic        gnt;
        logic [31:0] rdata;
        logic        e_ready, e_req, e_bv;
        logic [31:0] e_baddr;
        logic        e_bwr;
        logic [31:0] e_bwdata;
        logic        e_hold, e_rv;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(
        logic v, logic [31:0] addr, logic wr, logic [31:0] wdata, logic last, logic gnt,
        logic [31:0] rdata, logic e_ready, logic e_req, logic e_bv, logic [31:0] e_baddr,
        logic e_bwr, logic [31:0] e_bwdata, logic e_hold, logic e_rv, logic [31:0] e_rd,
        logic e_err);
        vec_t r;
        r.v = v; r.addr = addr; r.wr = wr; r.wdata = wdata; r.last = last; r.gnt = gnt;
        r.rdata = rdata; r.e_ready = e_ready; r.e_req = e_req; r.e_bv = e_bv;
        r.e_baddr = e_baddr; r.e_bwr = e_bwr; r.e_bwdata = e_bwdata; r.e_hold = e_hold;
        r.e_rv = e_rv; r.e_rd = e_rd; r.e_err = e_err;
        return r;
    endfunction

    task automatic idle_inputs();
        cmd_valid_a = 1'b0; cmd_addr_a = '0; cmd_wr_a = 1'b0; cmd_wdata_a = '0; cmd_last_a = 1'b0;
        cmd_valid_b = 1'b0; cmd_addr_b = '0; cmd_wr_b = 1'b0; cmd_wdata_b = '0; cmd_last_b = 1'b0;
        bus_rdata_a = '0; bus_rdata_b = '0;
    endtask

    task automatic push_a(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic last);
        cmd_valid_a = 1'b1; cmd_addr_a = addr; cmd_wr_a = wr; cmd_wdata_a = wdata;
        cmd_last_a = last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [17];

    typedef struct {
        logic [31:0] addr;
        logic        hold;
    } obs_t;
    obs_t obs[$];
    int   overlap;

    initial begin
        //             v  addr   wr wdata last gnt rdata  | rdy req bv baddr  bwr bwdata hold rv rd     err
        vecs[0]  = mk(1, 32'h10, 1, 32'hA5, 1, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[1]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 1, 1, 32'h10, 1, 32'hA5, 0, 0, 32'h0,    0);
        vecs[2]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[3]  = mk(1, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[4]  = mk(1, 32'h4,  0, 32'h0,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[5]  = mk(1, 32'h8,  0, 32'h0,  1, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[6]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 1, 1, 32'h0,  0, 32'h0,  1, 0, 32'h0,    0);
        vecs[7]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h1111, 1, 1, 1, 32'h4,  0, 32'h0,  1, 1, 32'h1111, 0);
        vecs[8]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h2222, 1, 1, 1, 32'h8,  0, 32'h0,  0, 1, 32'h2222, 0);
        vecs[9]  = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h3333, 1, 0, 0, 32'h0,  0, 32'h0,  0, 1, 32'h3333, 0);
        vecs[10] = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[11] = mk(1, 32'h20, 1, 32'h1,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[12] = mk(1, 32'h24, 1, 32'h2,  1, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[13] = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 1, 1, 32'h20, 1, 32'h1,  1, 0, 32'h0,    0);
        vecs[14] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    1, 1, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    0);
        vecs[15] = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 1, 1, 32'h24, 1, 32'h2,  0, 0, 32'h0,    1);
        vecs[16] = mk(0, 32'h0,  0, 32'h0,  0, 1, 32'h0,    1, 0, 0, 32'h0,  0, 32'h0,  0, 0, 32'h0,    1);

        arb_mode = 1'b0;
        gnt_en_a = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset request",   {31'b0, request_a},   32'd0);
        check("reset hold",      {31'b0, hold_a},      32'd0);
        check("reset bus_valid", {31'b0, bus_valid_a}, 32'd0);
        check("reset cmd_ready", {31'b0, cmd_ready_a}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        check("reset seq_err",   {31'b0, seq_err_a},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, 3-beat read with data return, then a burst with one withheld grant.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cmd_valid_a = vecs[i].v;    cmd_addr_a  = vecs[i].addr;
            cmd_wr_a    = vecs[i].wr;   cmd_wdata_a = vecs[i].wdata;
            cmd_last_a  = vecs[i].last; gnt_en_a    = vecs[i].gnt;
            bus_rdata_a = vecs[i].rdata;
            #1;
            check($sformatf("v%0d cmd_ready", i), {31'b0, cmd_ready_a}, {31'b0, vecs[i].e_ready});
            check($sformatf("v%0d request", i),   {31'b0, request_a},   {31'b0, vecs[i].e_req});
            check($sformatf("v%0d bus_valid", i), {31'b0, bus_valid_a}, {31'b0, vecs[i].e_bv});
            check($sformatf("v%0d bus_addr", i),  bus_addr_a,           vecs[i].e_baddr);
            check($sformatf("v%0d bus_wr", i),    {31'b0, bus_wr_a},    {31'b0, vecs[i].e_bwr});
            check($sformatf("v%0d bus_wdata", i), bus_wdata_a,          vecs[i].e_bwdata);
            check($sformatf("v%0d hold", i),      {31'b0, hold_a},      {31'b0, vecs[i].e_hold});
            check($sformatf("v%0d rsp_valid", i), {31'b0, rsp_valid_a}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                check($sformatf("v%0d rsp_rdata", i), rsp_rdata_a, vecs[i].e_rd);
            check($sformatf("v%0d seq_err", i),   {31'b0, seq_err_a},   {31'b0, vecs[i].e_err});
        end

        // Oversize sequence: four non-last beats fill the FIFO and never request.
        do_reset();
        gnt_en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_a(32'h40 + 32'(4 * i), 1'b1, 32'(i), 1'b0);
            #1;
            check($sformatf("ovf push%0d request", i), {31'b0, request_a}, 32'd0);
            check($sformatf("ovf push%0d ready", i),   {31'b0, cmd_ready_a}, 32'd1);
        end
        @(negedge clk);
        push_a(32'h50, 1'b1, 32'h9, 1'b1);
        #1;
        check("ovf full ready",   {31'b0, cmd_ready_a}, 32'd0);
        check("ovf full request", {31'b0, request_a},   32'd0);
        @(negedge clk);
        cmd_valid_a = 1'b0;
        #1;
        check("ovf seq_err",      {31'b0, seq_err_a},   32'd1);
        check("ovf still ready0", {31'b0, cmd_ready_a}, 32'd0);
        check("ovf no request",   {31'b0, request_a},   32'd0);

        // Reset asserted while beat 2 of 3 is on the bus.
        do_reset();
        gnt_en_a = 1'b1;
        @(negedge clk); push_a(32'h60, 1'b0, 32'h0, 1'b0);
        @(negedge clk); push_a(32'h64, 1'b0, 32'h0, 1'b0);
        @(negedge clk); push_a(32'h68, 1'b0, 32'h0, 1'b1);
        @(negedge clk); cmd_valid_a = 1'b0;
        #1;
        check("rst beat1 addr", bus_addr_a, 32'h60);
        @(negedge clk);
        #1;
        check("rst beat2 addr",  bus_addr_a,           32'h64);
        check("rst beat2 rsp",   {31'b0, rsp_valid_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst async request",   {31'b0, request_a},   32'd0);
        check("rst async hold",      {31'b0, hold_a},      32'd0);
        check("rst async bus_valid", {31'b0, bus_valid_a}, 32'd0);
        check("rst async rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        check("rst async cmd_ready", {31'b0, cmd_ready_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst after request",   {31'b0, request_a},   32'd0);
        check("rst after cmd_ready", {31'b0, cmd_ready_a}, 32'd1);
        check("rst after bus_valid", {31'b0, bus_valid_a}, 32'd0);

        // Two requesters through the arbiter model, each with a 2-beat sequence.
        do_reset();
        arb_mode = 1'b1;
        @(negedge clk);
        push_a(32'h100, 1'b1, 32'hA0, 1'b0);
        cmd_valid_b = 1'b1; cmd_addr_b = 32'h200; cmd_wr_b = 1'b1; cmd_wdata_b = 32'hB0; cmd_last_b = 1'b0;
        @(negedge clk);
        push_a(32'h104, 1'b1, 32'hA1, 1'b1);
        cmd_addr_b = 32'h204; cmd_wdata_b = 32'hB1; cmd_last_b = 1'b1;
        overlap = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cmd_valid_a = 1'b0;
            cmd_valid_b = 1'b0;
            #1;
            if (bus_valid_a && bus_valid_b) overlap++;
            if (bus_valid_a) obs.push_back('{addr: bus_addr_a, hold: hold_a});
            if (bus_valid_b) obs.push_back('{addr: bus_addr_b, hold: hold_b});
        end
        check("dual overlap cycles", 32'(overlap), 32'd0);
        check("dual beat count", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            check("dual beat0 addr", obs[0].addr, 32'h100);
            check("dual beat1 addr", obs[1].addr, 32'h104);
            check("dual beat2 addr", obs[2].addr, 32'h200);
            check("dual beat3 addr", obs[3].addr, 32'h204);
            check("dual holds", {28'b0, obs[0].hold, obs[1].hold, obs[2].hold, obs[3].hold},
                  32'b1010);
        end
        check("dual seq_err a", {31'b0, seq_err_a}, 32'd0);
        check("dual seq_err b", {31'b0, seq_err_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
